_sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer that consumes a single-bit data stream, such as the registered output of the team's flip-flop cells, and assembles it into a WIDTH-bit word. A one-cycle `start` strobe frames each word. The block raises a one-cycle `valid` when the word is complete. It is the stage directly downstream of the bit-level flip-flop chain and feeds word-level consumers (registers, counters, display decoders).

---
 rtl/_sipo_deser_pkg.sv | 27 ++
 rtl/_sipo_deser_shift_reg.sv | 51 +++++
 rtl/_sipo_deser.sv | 118 +++++++++++
 tb/tb__sipo_deser.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/_sipo_deser_pkg.sv
// ============================================================================
// Module      : _sipo_deser_pkg
// Description : State encoding and width helper shared by the SIPO deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package _sipo_deser_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/_sipo_deser_shift_reg.sv
// ============================================================================
// Module      : _sipo_shift_reg
// Description : WIDTH-bit serial shift register with clear, enable and direction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module _sipo_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // shifted is the register value after this edge's shift, including din
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shifted = {sr_q[WIDTH-2:0], din};
        end else begin : g_lsb_first
            assign shifted = {din, sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (en) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/_sipo_deser.sv
// ============================================================================
// Module      : _sipo_deser
// Description : Start-framed serial-in/parallel-out deserializer with overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module _sipo_deser
    import _sipo_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             abort,
    input  logic             start,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] dout_q,    dout_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;
    logic             sr_clr;
    logic             sr_en;
    logic [WIDTH-1:0] w_shifted;

    _sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (sr_clr),
        .en      (sr_en),
        .din     (din),
        .shifted (w_shifted)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        sr_clr    = 1'b0;
        sr_en     = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            cnt_d     = '0;
            sr_clr    = 1'b1;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        sr_clr  = 1'b1;
                    end
                end
                default: begin
                    sr_en = 1'b1;
                    if (cnt_q == LAST) begin
                        dout_d  = w_shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        // A start on the completion edge chains the next word
                        if (start) begin
                            sr_clr = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (start) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign busy    = (state_q == SHIFT);
    assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb__sipo_deser.sv
// ============================================================================
// Module      : tb__sipo_deser
// Description : Scoreboard bench driving an MSB-first and an LSB-first instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb__sipo_deser;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       abort = 1'b0;
    logic       start = 1'b0;
    logic       din = 1'b0;

    logic [7:0] dout_m, dout_l;
    logic       valid_m, valid_l;
    logic       busy_m, busy_l;
    logic       overrun_m, overrun_l;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];
    logic       pv_m = 1'b0;
    logic       pv_l = 1'b0;

    always #5 clk = ~clk;

    _sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .clk     (clk),
        .reset_n (reset_n),
        .abort   (abort),
        .start   (start),
        .din     (din),
        .dout    (dout_m),
        .valid   (valid_m),
        .busy    (busy_m),
        .overrun (overrun_m)
    );

    _sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk     (clk),
        .reset_n (reset_n),
        .abort   (abort),
        .start   (start),
        .din     (din),
        .dout    (dout_l),
        .valid   (valid_l),
        .busy    (busy_l),
        .overrun (overrun_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop expected words whenever an instance presents valid
    always @(negedge clk) begin
        if (valid_m) begin
            chk("valid_pulse_msb", {31'd0, pv_m}, 32'd0);
            if (exp_m.size() == 0) chk("unexpected_valid_msb", 32'd1, 32'd0);
            else chk("dout_msb", {24'd0, dout_m}, {24'd0, exp_m.pop_front()});
        end
        pv_m = valid_m;
    end

    always @(negedge clk) begin
        if (valid_l) begin
            chk("valid_pulse_lsb", {31'd0, pv_l}, 32'd0);
            if (exp_l.size() == 0) chk("unexpected_valid_lsb", 32'd1, 32'd0);
            else chk("dout_lsb", {24'd0, dout_l}, {24'd0, exp_l.pop_front()});
        end
        pv_l = valid_l;
    end

    task automatic strobe();
        @(negedge clk);
        start = 1'b1;
        din   = 1'b0;
        abort = 1'b0;
    endtask

    // Serial bits of w sent MSB of w first; start_idx 8 means no extra start
    task automatic bits(input logic [7:0] w, input int start_idx, input bit abort_last, input bit expect_word);
        if (expect_word) begin
            exp_m.push_back(w);
            exp_l.push_back(rev8(w));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_msb_in_word", {31'd0, busy_m}, 32'd1);
            chk("busy_lsb_in_word", {31'd0, busy_l}, 32'd1);
            start = (i == start_idx);
            din   = w[7-i];
            abort = abort_last && (i == 7);
        end
    endtask

    task automatic finish(input bit busy_exp, input bit ovr_exp);
        @(negedge clk);
        chk("valid_at_e8_msb", {31'd0, valid_m}, 32'd1);
        chk("valid_at_e8_lsb", {31'd0, valid_l}, 32'd1);
        chk("busy_after_word", {31'd0, busy_m}, {31'd0, busy_exp});
        chk("overrun_after_word", {31'd0, overrun_m}, {31'd0, ovr_exp});
        start = 1'b0;
        din   = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("valid_low_after", {31'd0, valid_m}, 32'd0);
    endtask

    initial begin
        #10000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_dout", {24'd0, dout_m}, 32'd0);
        chk("reset_valid", {31'd0, valid_m}, 32'd0);
        chk("reset_busy", {31'd0, busy_m}, 32'd0);
        chk("reset_overrun", {31'd0, overrun_m}, 32'd0);
        reset_n = 1'b1;

        // Basic word: MSB-first B2, LSB-first 4D
        strobe();
        bits(8'hB2, 8, 1'b0, 1'b1);
        finish(1'b0, 1'b0);
        chk("basic_lsb_value", {24'd0, dout_l}, 32'h4D);

        // Back-to-back B2 then 5A, busy held across the boundary
        strobe();
        bits(8'hB2, 7, 1'b0, 1'b1);
        bits(8'h5A, 8, 1'b0, 1'b1);
        finish(1'b0, 1'b0);

        // Overrun: start during bit 3, word still lands, flag sticky until abort
        strobe();
        bits(8'h96, 3, 1'b0, 1'b1);
        finish(1'b0, 1'b1);
        chk("overrun_sticky", {31'd0, overrun_m}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        chk("overrun_cleared", {31'd0, overrun_m}, 32'd0);
        abort = 1'b0;

        // Abort on completion edge: no valid, dout keeps 96
        strobe();
        bits(8'hE7, 8, 1'b1, 1'b0);
        @(negedge clk);
        chk("abort_no_valid", {31'd0, valid_m}, 32'd0);
        chk("abort_dout_msb", {24'd0, dout_m}, 32'h96);
        chk("abort_dout_lsb", {24'd0, dout_l}, {24'd0, rev8(8'h96)});
        chk("abort_idle", {31'd0, busy_m}, 32'd0);
        abort = 1'b0;
        din   = 1'b0;

        // Reset mid-word, with overrun set, clears outputs without a clock edge
        strobe();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = (i == 1);
            din   = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        chk("pre_reset_overrun", {31'd0, overrun_m}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy_m}, 32'd0);
        chk("async_rst_dout_msb", {24'd0, dout_m}, 32'd0);
        chk("async_rst_dout_lsb", {24'd0, dout_l}, 32'd0);
        chk("async_rst_overrun", {31'd0, overrun_l}, 32'd0);
        chk("async_rst_valid", {31'd0, valid_l}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        strobe();
        bits(8'hC3, 8, 1'b0, 1'b1);
        finish(1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drained_msb", exp_m.size(), 32'd0);
        chk("sb_drained_lsb", exp_l.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
